// File: rtl/store_buffer_access_logic.sv
// Data-side access logic: DEPTH-entry store buffer drained to the dcache, LL/SC link register, halt/flush.
// Optional macro STORE_FORWARD_EN enables store-to-load forwarding from the buffer.
module store_buffer_access_logic #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          dmemREN,
    input  logic          dmemWEN,
    input  logic          datomic,
    input  logic          halt,
    input  logic [AW-1:0] dmemaddr,
    input  logic [DW-1:0] dmemstore,
    output logic          dhit,
    output logic [DW-1:0] dmemload,
    output logic [AW-1:0] daddr,
    output logic [DW-1:0] dstore,
    output logic          dREN,
    output logic          dWEN,
    input  logic          hit,
    input  logic [DW-1:0] ddata,
    input  logic          snoop_valid,
    input  logic [AW-1:0] snoop_addr,
    output logic          wempty,
    output logic          flushed
);
    // state     | meaning
    // IDLE      | accept requests; start a load or a drain
    // LOAD      | cache read in flight for a non-forwarded load/LL
    // DRAIN     | writing head entry to the cache; stores still accepted
    // HALTDRAIN | halt seen; drain remaining entries, no requests served
    // FLUSHED   | buffer empty after halt; terminal until reset
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HALTDRAIN, FLUSHED} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t        state, state_next;
    logic [AW-1:0] buf_addr [DEPTH];
    logic [DW-1:0] buf_data [DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_next;
    logic [AW-1:0] link_addr;
    logic          link_valid;
    logic          wempty_q;

    logic          push, pop, link_set, link_clr;
    logic          can_push, sc_ok, req_ok, load_wait, load_go, snoop_hit;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          dhit_c, dren_c, dwen_c;
    logic [DW-1:0] dmemload_c, dstore_c;
    logic [AW-1:0] daddr_c;

    function automatic logic word_eq(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return a[AW-1:2] == b[AW-1:2];
    endfunction

`ifdef STORE_FORWARD_EN
    logic [PW-1:0] fwd_idx;

    // Oldest to youngest, so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PW'(k);
            if (CW'(k) < count && word_eq(buf_addr[fwd_idx], dmemaddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[fwd_idx];
            end
        end
    end
    assign load_go = 1'b1;
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
    // Without forwarding a load may only reach the cache once all older stores have.
    assign load_go  = wempty_q;
`endif

    assign snoop_hit = snoop_valid && word_eq(snoop_addr, link_addr);

    always_comb begin
        state_next = state;
        dhit_c     = 1'b0;
        dmemload_c = '0;
        daddr_c    = '0;
        dstore_c   = '0;
        dren_c     = 1'b0;
        dwen_c     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        link_set   = 1'b0;
        link_clr   = 1'b0;
        load_wait  = 1'b0;
        req_ok     = !halt && (state == IDLE || state == DRAIN);

        case (state)
            DRAIN, HALTDRAIN: begin
                if (count != '0) begin
                    dwen_c   = 1'b1;
                    daddr_c  = buf_addr[head];
                    dstore_c = buf_data[head];
                    pop      = hit;
                end
            end
            LOAD: begin
                dren_c  = 1'b1;
                daddr_c = dmemaddr;
            end
            default: ;
        endcase

        can_push = (count < CW'(DEPTH)) || pop;
        sc_ok    = link_valid && word_eq(link_addr, dmemaddr) && !snoop_hit;

        if (req_ok) begin
            if (dmemWEN) begin
                if (datomic && !sc_ok) begin
                    dhit_c   = 1'b1;
                    link_clr = 1'b1;
                end else if (can_push) begin
                    dhit_c     = 1'b1;
                    push       = 1'b1;
                    dmemload_c = datomic ? DW'(1) : '0;
                    link_clr   = datomic || word_eq(dmemaddr, link_addr);
                end
            end else if (dmemREN) begin
                if (fwd_hit) begin
                    dhit_c     = 1'b1;
                    dmemload_c = fwd_data;
                    link_set   = datomic;
                end else begin
                    load_wait = 1'b1;
                end
            end
        end

        if (state == LOAD && hit) begin
            dhit_c     = 1'b1;
            dmemload_c = ddata;
            link_set   = dmemREN && datomic;
        end

        count_next = count + CW'(push) - CW'(pop);

        case (state)
            IDLE: begin
                if (halt)
                    state_next = HALTDRAIN;
                else if (load_wait && load_go)
                    state_next = LOAD;
                else if (count != '0)
                    state_next = DRAIN;
            end
            LOAD: begin
                if (hit)
                    state_next = halt ? HALTDRAIN : IDLE;
            end
            DRAIN: begin
                if (halt)
                    state_next = HALTDRAIN;
                else if (pop && (count_next == '0 || (load_wait && load_go)))
                    state_next = IDLE;
            end
            HALTDRAIN: begin
                if (count_next == '0)
                    state_next = FLUSHED;
            end
            default: ;
        endcase
    end

    // Nothing is presented to the datapath or the cache while reset is held.
    assign dhit     = nRST && dhit_c;
    assign dREN     = nRST && dren_c;
    assign dWEN     = nRST && dwen_c;
    assign dmemload = nRST ? dmemload_c : '0;
    assign daddr    = nRST ? daddr_c : '0;
    assign dstore   = nRST ? dstore_c : '0;
    assign wempty   = wempty_q;
    assign flushed  = (state == FLUSHED);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            link_addr  <= '0;
            link_valid <= 1'b0;
            wempty_q   <= 1'b1;
        end else begin
            state    <= state_next;
            count    <= count_next;
            wempty_q <= (count_next == '0);
            if (push)
                tail <= tail + PW'(1);
            if (pop)
                head <= head + PW'(1);
            if (link_set) begin
                link_valid <= 1'b1;
                link_addr  <= dmemaddr;
            end else if (link_clr || snoop_hit) begin
                link_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            buf_addr[tail] <= dmemaddr;
            buf_data[tail] <= dmemstore;
        end
    end

endmodule

// File: tb/tb_store_buffer_access_logic.sv
// Directed bench for store_buffer_access_logic (DEPTH=4); expectations follow STORE_FORWARD_EN when defined.
module tb_store_buffer_access_logic;
    logic        CLK = 1'b0;
    logic        nRST, dmemREN, dmemWEN, datomic, halt, hit, snoop_valid;
    logic [31:0] dmemaddr, dmemstore, ddata, snoop_addr;
    logic        dhit, dREN, dWEN, wempty, flushed;
    logic [31:0] dmemload, daddr, dstore;

    int n_cmp  = 0;
    int n_fail = 0;

    store_buffer_access_logic #(.DEPTH(4), .DW(32), .AW(32)) dut (
        .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .halt(halt), .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit),
        .dmemload(dmemload), .daddr(daddr), .dstore(dstore), .dREN(dREN), .dWEN(dWEN),
        .hit(hit), .ddata(ddata), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
        .wempty(wempty), .flushed(flushed)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; dmemREN = 1'b1; dmemWEN = 1'b0; datomic = 1'b0; halt = 1'b0;
        hit = 1'b0; snoop_valid = 1'b0; dmemaddr = 32'h40; dmemstore = '0;
        ddata = '0; snoop_addr = '0;

        // reset with a pending load
        step(); step();
        chkb("rst_dhit", dhit, 1'b0);
        chkb("rst_dren", dREN, 1'b0);
        chkb("rst_dwen", dWEN, 1'b0);
        chkb("rst_wempty", wempty, 1'b1);
        chkb("rst_flushed", flushed, 1'b0);
        nRST = 1'b1; dmemREN = 1'b0;

        // fill to DEPTH with the cache stalled
        for (int i = 0; i < 4; i++) begin
            dmemWEN = 1'b1; dmemaddr = 32'h100 + 32'(4 * i); dmemstore = 32'hA0 + 32'(i);
            #1 chkb("fill_accept", dhit, 1'b1);
            step();
        end
        dmemaddr = 32'h110; dmemstore = 32'hA4;
        #1 chkb("fill_full_stall", dhit, 1'b0);
        chkb("fill_dwen", dWEN, 1'b1);
        chk("fill_head_addr", daddr, 32'h100);
        chk("fill_head_data", dstore, 32'hA0);
        step();
        hit = 1'b1;
        #1 chkb("fill_accept_on_pop", dhit, 1'b1);
        step();
        dmemWEN = 1'b0;
        #1 chkb("fill_still_full", wempty, 1'b0);
        for (int j = 1; j < 5; j++) begin
            chkb("fill_drain_dwen", dWEN, 1'b1);
            chk("fill_drain_addr", daddr, 32'h100 + 32'(4 * j));
            chk("fill_drain_data", dstore, 32'hA0 + 32'(j));
            step();
        end
        hit = 1'b0;
        #1 chkb("fill_empty", wempty, 1'b1);
        chkb("fill_idle_no_dwen", dWEN, 1'b0);

        // two stores to one word, then a load of it
        dmemWEN = 1'b1; dmemaddr = 32'h200; dmemstore = 32'h11;
        #1 chkb("fwd_st1", dhit, 1'b1);
        step();
        dmemstore = 32'h22;
        #1 chkb("fwd_st2", dhit, 1'b1);
        step();
        dmemWEN = 1'b0; dmemREN = 1'b1; ddata = 32'h22;
`ifdef STORE_FORWARD_EN
        #1 chkb("fwd_dhit", dhit, 1'b1);
        chk("fwd_data", dmemload, 32'h22);
        chkb("fwd_no_dren", dREN, 1'b0);
        step();
        dmemREN = 1'b0; hit = 1'b1;
        #1;
        for (int k = 0; k < 12 && !wempty; k++) step();
        chkb("fwd_drained", wempty, 1'b1);
`else
        #1 chkb("nofwd_wait", dhit, 1'b0);
        hit = 1'b1;
        #1;
        for (int k = 0; k < 12 && !dhit; k++) begin step(); #1; end
        chkb("nofwd_dhit", dhit, 1'b1);
        chkb("nofwd_dren", dREN, 1'b1);
        chk("nofwd_data", dmemload, 32'h22);
        chkb("nofwd_wempty", wempty, 1'b1);
        step();
        dmemREN = 1'b0;
`endif
        hit = 1'b0;

        // LL then SC succeeds
        dmemREN = 1'b1; datomic = 1'b1; dmemaddr = 32'h300;
        #1 chkb("ll_miss_wait", dhit, 1'b0);
        step();
        hit = 1'b1; ddata = 32'h5;
        #1 chkb("ll_dren", dREN, 1'b1);
        chkb("ll_dhit", dhit, 1'b1);
        chk("ll_data", dmemload, 32'h5);
        step();
        dmemREN = 1'b0; dmemWEN = 1'b1; dmemstore = 32'h9; hit = 1'b0;
        #1 chkb("sc_ok_dhit", dhit, 1'b1);
        chk("sc_ok_result", dmemload, 32'h1);
        step();
        dmemWEN = 1'b0; datomic = 1'b0;
        #1 chkb("sc_ok_enqueued", wempty, 1'b0);
        for (int k = 0; k < 8 && !dWEN; k++) begin step(); #1; end
        chk("sc_drain_addr", daddr, 32'h300);
        chk("sc_drain_data", dstore, 32'h9);
        hit = 1'b1;
        step();
        hit = 1'b0;

        // LL, snoop to the linked word, then SC fails
        dmemREN = 1'b1; datomic = 1'b1; dmemaddr = 32'h300;
        #1 step();
        hit = 1'b1;
        #1 chkb("ll2_dhit", dhit, 1'b1);
        step();
        dmemREN = 1'b0; datomic = 1'b0; hit = 1'b0;
        snoop_valid = 1'b1; snoop_addr = 32'h300;
        step();
        snoop_valid = 1'b0;
        dmemWEN = 1'b1; datomic = 1'b1; dmemstore = 32'h9;
        #1 chkb("sc_snooped_dhit", dhit, 1'b1);
        chk("sc_snooped_result", dmemload, 32'h0);
        step();
        dmemWEN = 1'b0; datomic = 1'b0;
        #1 chkb("sc_snooped_no_enq", wempty, 1'b1);

        // LL, then SC in the same cycle as a snoop to the same word fails
        dmemREN = 1'b1; datomic = 1'b1;
        #1 step();
        hit = 1'b1;
        #1 step();
        dmemREN = 1'b0; hit = 1'b0; dmemWEN = 1'b1;
        snoop_valid = 1'b1; snoop_addr = 32'h300;
        #1 chk("sc_coincident_result", dmemload, 32'h0);
        step();
        dmemWEN = 1'b0; datomic = 1'b0; snoop_valid = 1'b0;
        #1 chkb("sc_coincident_no_enq", wempty, 1'b1);

        // store/drain pairs wrapping the pointers
        for (int i = 0; i < 10; i++) begin
            dmemWEN = 1'b1; dmemaddr = 32'h400 + 32'(4 * i); dmemstore = 32'hB0 + 32'(i);
            #1 chkb("wrap_accept", dhit, 1'b1);
            step();
            dmemWEN = 1'b0;
            #1;
            for (int k = 0; k < 8 && !dWEN; k++) begin step(); #1; end
            chk("wrap_addr", daddr, 32'h400 + 32'(4 * i));
            chk("wrap_data", dstore, 32'hB0 + 32'(i));
            hit = 1'b1;
            step();
            hit = 1'b0;
        end
        #1 chkb("wrap_empty", wempty, 1'b1);

        // halt drains three stores in order, then flushes
        for (int j = 0; j < 3; j++) begin
            dmemWEN = 1'b1; dmemaddr = 32'h100 + 32'(4 * j); dmemstore = 32'hC0 + 32'(j);
            #1 chkb("halt_fill", dhit, 1'b1);
            step();
        end
        halt = 1'b1; dmemaddr = 32'h500; dmemstore = 32'hDD;
        #1 chkb("halt_ignores_store", dhit, 1'b0);
        step();
        dmemWEN = 1'b0;
        for (int j = 0; j < 3; j++) begin
            hit = 1'b1;
            #1 chkb("halt_dwen", dWEN, 1'b1);
            chk("halt_addr", daddr, 32'h100 + 32'(4 * j));
            chk("halt_data", dstore, 32'hC0 + 32'(j));
            chkb("halt_not_flushed", flushed, 1'b0);
            step();
        end
        hit = 1'b0;
        #1 chkb("flushed_set", flushed, 1'b1);
        chkb("flushed_no_dwen", dWEN, 1'b0);
        dmemREN = 1'b1; dmemaddr = 32'h100;
        for (int k = 0; k < 3; k++) begin
            step();
            chkb("flushed_sticky", flushed, 1'b1);
            chkb("flushed_no_dren", dREN, 1'b0);
            chkb("flushed_no_dhit", dhit, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
